// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes,
// FSM state encodings, ALU operation and PC source selector codes.
// MULTICYCLE_JUMP_EN: when defined, opcode J is a legal instruction.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] J      = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == R_TYPE) || (op == LW) ||
         (op == SW) || (op == BEQ);
`ifdef MULTICYCLE_JUMP_EN
    ok = ok || (op == J);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory state waits for mem_ready.
// Ports: clk, reset (async, low), active, mem_ready -> timeout.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] count;

  // count holds the number of wait cycles already spent, so the
  // WAIT_MAX-th waiting cycle sees count == WAIT_MAX-1.
  assign timeout = active && !mem_ready &&
                   (count == 8'(WAIT_MAX - 1));

  // Clears whenever not waiting, so entry to a memory state
  // always starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (active && !mem_ready && !timeout) begin
      count <= count + 8'd1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory wait timeout.
// Ports: clk, reset(async low), opcode, mem_ready -> datapath
// controls, mem_err, illegal_op, state. Macro MULTICYCLE_JUMP_EN.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       mem_err,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  logic   waiting;
  logic   timeout;

  assign state = state_q;

  assign waiting = (state_q == S_FETCH) ||
                   (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:
          if (mem_ready) state_q <= S_DECODE;
        S_DECODE:
          unique case (1'b1)
            (opcode == R_TYPE):
              state_q <= S_EXEC;
            (opcode == LW),
            (opcode == SW):
              state_q <= S_MEMADR;
            (opcode == BEQ):
              state_q <= S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
            (opcode == J):
              state_q <= S_JUMP;
`endif
            default:
              state_q <= S_FETCH;
          endcase
        S_MEMADR:
          state_q <= (opcode == SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:
          if (mem_ready) state_q <= S_MEMWB;
          else if (timeout) state_q <= S_FETCH;
        S_MEMWB:
          state_q <= S_FETCH;
        S_MEMWR:
          if (mem_ready || timeout) state_q <= S_FETCH;
        S_EXEC:
          state_q <= S_RTYPEWB;
        S_RTYPEWB:
          state_q <= S_FETCH;
        S_BRANCH:
          state_q <= S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
        S_JUMP:
          state_q <= S_FETCH;
`endif
        default:
          state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALU_ADD;
    PCSource    = PC_ALU;
    illegal_op  = 1'b0;
    mem_err     = timeout;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_BOFS;
        illegal_op = !op_legal(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PC_ALUOUT;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PC_JUMP;
      end
`endif
      default: begin
        MemRead = 1'b0;
      end
    endcase
    // Reset is asynchronous: suppress every state-changing strobe
    // while it is held, even though FETCH decodes combinationally.
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      mem_err     = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (WAIT_MAX=4).
// Control vector: {PCW,PCWC,IorD,MRd,MWr,M2R,IRW,RDst,RW,SrcA,SrcB,Op,PCSrc}.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       mem_err, illegal_op;
  logic [3:0] state;
  logic [15:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource),
    .mem_err(mem_err), .illegal_op(illegal_op),
    .state(state)
  );

  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead,
                MemWrite, MemtoReg, IRWrite, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  localparam logic [15:0] C_FETCH   = 16'h9210;
  localparam logic [15:0] C_FWAIT   = 16'h1010;
  localparam logic [15:0] C_DECODE  = 16'h0030;
  localparam logic [15:0] C_MEMADR  = 16'h0060;
  localparam logic [15:0] C_MEMRD   = 16'h3000;
  localparam logic [15:0] C_MEMWB   = 16'h0480;
  localparam logic [15:0] C_MEMWR   = 16'h2800;
  localparam logic [15:0] C_EXEC    = 16'h0048;
  localparam logic [15:0] C_RTYPEWB = 16'h0180;
  localparam logic [15:0] C_BRANCH  = 16'h4045;
  localparam logic [15:0] C_JUMP    = 16'h8002;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already set; checks, then
  // advances to the next posedge+1.
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [15:0] c, input logic err,
                     input logic ill);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".mem_err"}, 32'(mem_err), 32'(err));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held: FETCH, writes suppressed even with mem_ready
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.ctl", 32'(ctl), 32'(C_FWAIT));
    mem_ready = 1'b1;
    #1;
    check("rst.ctl_rdy", 32'(ctl), 32'(C_FWAIT));
    check("rst.mem_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1;

    // lw, zero wait: 0,1,2,3,4 then FETCH
    reset = 1'b1;
    opcode = 6'b100011;
    cyc("lw0", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("lw1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("lw2", 4'd2, C_MEMADR, 1'b0, 1'b0);
    cyc("lw3", 4'd3, C_MEMRD, 1'b0, 1'b0);
    cyc("lw4", 4'd4, C_MEMWB, 1'b0, 1'b0);

    // sw, three wait cycles in MEMWR
    opcode = 6'b101011;
    cyc("sw0", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("sw1", 4'd1, C_DECODE, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cyc("sw2", 4'd2, C_MEMADR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("sw5w", 4'd5, C_MEMWR, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cyc("sw5r", 4'd5, C_MEMWR, 1'b0, 1'b0);

    // beq
    opcode = 6'b000100;
    cyc("beq0", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("beq1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("beq8", 4'd8, C_BRANCH, 1'b0, 1'b0);

    // R-type
    opcode = 6'b000000;
    cyc("rt0", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("rt1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("rt6", 4'd6, C_EXEC, 1'b0, 1'b0);
    cyc("rt7", 4'd7, C_RTYPEWB, 1'b0, 1'b0);

    // illegal opcode
    opcode = 6'b111111;
    cyc("ill0", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("ill1", 4'd1, C_DECODE, 1'b0, 1'b1);

    // jump: legal only with the macro
    opcode = 6'b000010;
    cyc("j0", 4'd0, C_FETCH, 1'b0, 1'b0);
`ifdef MULTICYCLE_JUMP_EN
    cyc("j1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("j9", 4'd9, C_JUMP, 1'b0, 1'b0);
`else
    cyc("j1", 4'd1, C_DECODE, 1'b0, 1'b1);
`endif

    // FETCH timeout: pulse on 4th wait cycle, stay in FETCH
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("fto_w", 4'd0, C_FWAIT, 1'b0, 1'b0);
    cyc("fto_err", 4'd0, C_FWAIT, 1'b1, 1'b0);
    // counter restarted: ready on the 4th cycle wins
    for (int i = 0; i < 3; i++)
      cyc("fbd_w", 4'd0, C_FWAIT, 1'b0, 1'b0);
    mem_ready = 1'b1;
    opcode = 6'b100011;
    cyc("fbd_rdy", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("fbd1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("fbd2", 4'd2, C_MEMADR, 1'b0, 1'b0);

    // MEMRD timeout: abort to FETCH, never MEMWB
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("mto_w", 4'd3, C_MEMRD, 1'b0, 1'b0);
    cyc("mto_err", 4'd3, C_MEMRD, 1'b1, 1'b0);
    mem_ready = 1'b1;
    cyc("mto_f", 4'd0, C_FETCH, 1'b0, 1'b0);
    cyc("mto_1", 4'd1, C_DECODE, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cyc("mto_2", 4'd2, C_MEMADR, 1'b0, 1'b0);

    // async reset during MEMRD, between clock edges
    #1;
    check("ar.pre", 32'(state), 32'd3);
    reset = 1'b0;
    #1;
    check("ar.state", 32'(state), 32'd0);
    check("ar.ctl", 32'(ctl), 32'(C_FWAIT));
    mem_ready = 1'b1;
    #1;
    check("ar.ctl_rdy", 32'(ctl), 32'(C_FWAIT));
    check("ar.mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    opcode = 6'b000000;
    #1;
    check("ar.rel", 32'(ctl), 32'(C_FETCH));
    @(posedge clk);
    #1;
    cyc("ar1", 4'd1, C_DECODE, 1'b0, 1'b0);
    cyc("ar6", 4'd6, C_EXEC, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
